// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the MEM stage: load/store funct3 codes,
// access sizes and the memory-access FSM encoding.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/memory_access_stage_lsu_align.sv
// Combinational load/store alignment: access-size decode, alignment check,
// store lane steering with byte enables, and load extract/extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        aligned,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata,
    output logic [31:0] load_data
);

    acc_size_e   size_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Access size; stores and loads disagree on the meaning of funct3[2]
    always_comb begin
        size_s = SZ_W;
        if (is_store) begin
            case (funct3)
                F3_SB:   size_s = SZ_B;
                F3_SH:   size_s = SZ_H;
                default: size_s = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size_s = SZ_B;
                F3_LH, F3_LHU: size_s = SZ_H;
                default:       size_s = SZ_W;
            endcase
        end
    end

    // Alignment check and store lane steering
    always_comb begin
        aligned     = 1'b0;
        store_be    = 4'b1111;
        store_wdata = store_data;
        case (size_s)
            SZ_B: begin
                aligned     = 1'b1;
                store_be    = 4'b0001 << addr_lo;
                store_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                aligned     = (addr_lo[0] == 1'b0);
                store_be    = 4'b0011 << {addr_lo[1], 1'b0};
                store_wdata = {2{store_data[15:0]}};
            end
            default: begin
                aligned     = (addr_lo == 2'b00);
                store_be    = 4'b1111;
                store_wdata = store_data;
            end
        endcase
    end

    // Load lane extraction
    always_comb begin
        byte_s = load_word[7:0];
        case (addr_lo)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            default: byte_s = load_word[31:24];
        endcase
        if (addr_lo[1]) begin
            half_s = load_word[31:16];
        end else begin
            half_s = load_word[15:0];
        end
    end

    // Sign/zero extension; unknown funct3 behaves as LW
    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LBU:  load_data = {24'd0, byte_s};
            F3_LHU:  load_data = {16'd0, half_s};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RV32I MEM stage: ready-handshaked data-memory port with timeout abort,
// misalignment trap and the MEM/WB pipeline register.
module memory_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data_out,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_write_data,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_r, state_next_s;
    logic [CW-1:0] cnt_r;
    logic        memop_s, aligned_s, stall_s;
    logic        accept_s, misal_s, done_s, timeout_s;
    logic [4:0]  rd_r;
    logic [2:0]  funct3_r;
    logic        reg_write_r, mem_to_reg_r, is_store_r;
    logic [31:0] alu_r;
    logic [2:0]  sel_funct3_s;
    logic [1:0]  sel_addr_lo_s;
    logic        sel_is_store_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s, ld_data_s;
    logic        dmem_req_r, dmem_we_r, wb_valid_r, wb_reg_write_r;
    logic        misaligned_r, bus_error_r;
    logic [31:0] dmem_addr_r, dmem_wdata_r, wb_write_data_r;
    logic [3:0]  dmem_be_r;
    logic [4:0]  wb_rd_r;

    assign memop_s = valid_in & (mem_read | mem_write);

    // Aligner sees live EX/MEM fields in IDLE and the latched copy in REQ
    always_comb begin
        if (state_r == MS_REQ) begin
            sel_funct3_s   = funct3_r;
            sel_addr_lo_s  = alu_r[1:0];
            sel_is_store_s = is_store_r;
        end else begin
            sel_funct3_s   = funct3;
            sel_addr_lo_s  = alu_result[1:0];
            sel_is_store_s = mem_write;
        end
    end

    lsu_align u_lsu_align (
        .funct3      (sel_funct3_s),
        .addr_lo     (sel_addr_lo_s),
        .is_store    (sel_is_store_s),
        .store_data  (rs2_data_out),
        .load_word   (dmem_rdata),
        .aligned     (aligned_s),
        .store_be    (st_be_s),
        .store_wdata (st_wdata_s),
        .load_data   (ld_data_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MS_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        accept_s     = 1'b0;
        misal_s      = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            MS_IDLE: begin
                if (memop_s && aligned_s) begin
                    accept_s     = 1'b1;
                    stall_s      = 1'b1;
                    state_next_s = MS_REQ;
                end else if (memop_s) begin
                    misal_s = 1'b1;
                end else begin
                    state_next_s = MS_IDLE;
                end
            end
            MS_REQ: begin
                if (dmem_ready) begin
                    done_s       = 1'b1;
                    state_next_s = MS_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = MS_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: state_next_s = MS_IDLE;
        endcase
    end

    // Counts REQ cycles spent waiting for dmem_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (state_r == MS_REQ && !dmem_ready && !timeout_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Memory port, latched instruction fields and MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req_r      <= 1'b0;
            dmem_we_r       <= 1'b0;
            dmem_addr_r     <= 32'd0;
            dmem_wdata_r    <= 32'd0;
            dmem_be_r       <= 4'd0;
            rd_r            <= 5'd0;
            funct3_r        <= 3'd0;
            reg_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            is_store_r      <= 1'b0;
            alu_r           <= 32'd0;
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_write_data_r <= 32'd0;
            misaligned_r    <= 1'b0;
            bus_error_r     <= 1'b0;
        end else begin
            misaligned_r <= 1'b0;
            bus_error_r  <= 1'b0;
            if (accept_s) begin
                dmem_req_r     <= 1'b1;
                dmem_we_r      <= mem_write;
                dmem_addr_r    <= {alu_result[31:2], 2'b00};
                dmem_wdata_r   <= st_wdata_s;
                dmem_be_r      <= mem_write ? st_be_s : 4'b1111;
                rd_r           <= rd;
                funct3_r       <= funct3;
                reg_write_r    <= reg_write;
                mem_to_reg_r   <= mem_to_reg;
                is_store_r     <= mem_write;
                alu_r          <= alu_result;
                wb_valid_r     <= 1'b0;
                wb_reg_write_r <= 1'b0;
            end else if (misal_s) begin
                wb_valid_r      <= 1'b1;
                wb_reg_write_r  <= 1'b0;
                wb_rd_r         <= rd;
                wb_write_data_r <= alu_result;
                misaligned_r    <= 1'b1;
            end else if (done_s) begin
                dmem_req_r      <= 1'b0;
                dmem_we_r       <= 1'b0;
                wb_valid_r      <= 1'b1;
                wb_reg_write_r  <= reg_write_r & ~is_store_r;
                wb_rd_r         <= rd_r;
                wb_write_data_r <= mem_to_reg_r ? ld_data_s : alu_r;
            end else if (timeout_s) begin
                dmem_req_r     <= 1'b0;
                dmem_we_r      <= 1'b0;
                wb_valid_r     <= 1'b1;
                wb_reg_write_r <= 1'b0;
                wb_rd_r        <= rd_r;
                bus_error_r    <= 1'b1;
            end else if (state_r == MS_IDLE) begin
                wb_valid_r      <= valid_in;
                wb_reg_write_r  <= reg_write & valid_in;
                wb_rd_r         <= rd;
                wb_write_data_r <= alu_result;
            end else begin
                dmem_req_r <= dmem_req_r;
            end
        end
    end

    assign stall         = stall_s;
    assign dmem_req      = dmem_req_r;
    assign dmem_we       = dmem_we_r;
    assign dmem_addr     = dmem_addr_r;
    assign dmem_wdata    = dmem_wdata_r;
    assign dmem_be       = dmem_be_r;
    assign wb_valid      = wb_valid_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_rd         = wb_rd_r;
    assign wb_write_data = wb_write_data_r;
    assign misaligned    = misaligned_r;
    assign bus_error     = bus_error_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized self-checking bench for memory_access_stage against a
// transaction-level model of the MEM stage (retire queue keyed by cycle).
module tb_memory_access_stage;

    localparam int TO = 4;

    logic        clk, reset;
    logic        valid_in, mem_read, mem_write, reg_write, mem_to_reg, dmem_ready;
    logic [31:0] alu_result, rs2_data_out, dmem_rdata;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, stall, wb_valid, wb_reg_write, misaligned, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, wb_write_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
        .rs2_data_out(rs2_data_out), .rd(rd), .funct3(funct3), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .stall(stall), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    typedef struct {
        int          cyc;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
    } retire_t;

    retire_t     q[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          stall_hits = 0, req_hits = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_st = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [3:0]  exp_be = 4'd0;
    logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_be = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte count of an access: stores decode only 000/001, loads also 100/101
    function automatic int acc_bytes(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input int off, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_data(input int n, input logic [31:0] d);
        if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, drive the memory side with a ready after d waiting cycles
    task automatic run_instr(input logic v, input logic mr, input logic mw, input logic rw,
                             input logic m2r, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rdv, input int d,
                             input logic [31:0] rdata);
        retire_t r;
        int      n, off;
        n   = acc_bytes(mw, f3);
        off = int'(addr[1:0]);
        valid_in = v; mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
        funct3 = f3; alu_result = addr; rs2_data_out = data; rd = rdv;
        dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        exp_req = 1'b0;
        r.cyc = cyc + 1; r.rw = 1'b0; r.rd = rdv; r.data = addr; r.chk_data = 1'b0;
        r.mis = 1'b0; r.berr = 1'b0;
        if (!(v && (mr || mw))) begin
            exp_stall = 1'b0;
            r.rw = rw; r.chk_data = 1'b1;
            if (v) q.push_back(r);
            step();
        end else if ((off % n) != 0) begin
            exp_stall = 1'b0;
            r.mis = 1'b1;
            q.push_back(r);
            step();
        end else begin
            exp_stall = 1'b1;
            step();
            exp_req = 1'b1; exp_we = mw; exp_st = mw;
            exp_addr = {addr[31:2], 2'b00};
            exp_be = 4'(((1 << n) - 1) << off);
            exp_wdata = st_data(n, data);
            for (int k = 0; k < TO; k++) begin
                valid_in = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
                alu_result = $urandom; rs2_data_out = $urandom; rd = 5'($urandom);
                funct3 = 3'($urandom); reg_write = 1'($urandom); mem_to_reg = 1'($urandom);
                dmem_rdata = $urandom;
                r.cyc = cyc + 1;
                if (k == d) begin
                    dmem_ready = 1'b1; dmem_rdata = rdata; exp_stall = 1'b0;
                    r.rw = rw & ~mw; r.chk_data = 1'b1;
                    r.data = m2r ? fmt_load(rdata, off, f3) : addr;
                    q.push_back(r);
                    step();
                    break;
                end else if (k == TO - 1) begin
                    dmem_ready = 1'b0; exp_stall = 1'b0; r.berr = 1'b1;
                    q.push_back(r);
                    step();
                end else begin
                    dmem_ready = 1'b0; exp_stall = 1'b1;
                    step();
                end
            end
            exp_req = 1'b0;
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                if (exp_st) begin
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("wb_valid", 32'(wb_valid), 32'd1);
                chk("wb_reg_write", 32'(wb_reg_write), 32'(q[0].rw));
                chk("misaligned", 32'(misaligned), 32'(q[0].mis));
                chk("bus_error", 32'(bus_error), 32'(q[0].berr));
                if (q[0].chk_data) begin
                    chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
                    chk("wb_write_data", wb_write_data, q[0].data);
                end
                void'(q.pop_front());
            end else begin
                chk("wb_valid_idle", 32'(wb_valid), 32'd0);
                chk("pulse_idle", 32'({misaligned, bus_error}), 32'd0);
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    chk("retire_missed", 32'(q[0].cyc), 32'(cyc));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Activity counters and captured request fields for directed expectations
    always @(negedge clk) begin
        if (stall) stall_hits++;
        if (dmem_req) begin
            req_hits++;
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata;
        end
    end

    initial begin
        int s0, r0, kind, d;
        logic [2:0]  f3;
        logic [31:0] a;
        reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        mem_to_reg = 1'b0; dmem_ready = 1'b0; alu_result = 32'd0; rs2_data_out = 32'd0;
        dmem_rdata = 32'd0; rd = 5'd0; funct3 = 3'd0;
        #12;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_write_data, 32'd0);
        chk("rst_pulses", 32'({misaligned, bus_error}), 32'd0);
        step();
        reset = 1'b0;
        chk_en = 1'b1;

        // ADD: single-cycle passthrough
        s0 = stall_hits;
        run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0);
        chk("add_wb_data", wb_write_data, 32'h0000_1234);
        chk("add_wb_rd", 32'(wb_rd), 32'd5);
        chk("add_stall", 32'(stall_hits - s0), 32'd0);

        // LB from byte lane 3, ready on first REQ cycle
        s0 = stall_hits;
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 0, 32'h80FF_0000);
        chk("lb_wb_data", wb_write_data, 32'hFFFF_FF80);
        chk("lb_stall", 32'(stall_hits - s0), 32'd1);

        // SH to upper half, ready after 3 waiting cycles
        s0 = stall_hits;
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd3, 3, 32'd0);
        chk("sh_addr", last_addr, 32'h0000_0200);
        chk("sh_be", 32'(last_be), 32'h0000_000C);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("sh_stall", 32'(stall_hits - s0), 32'd4);

        // Misaligned LW
        r0 = req_hits;
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0101, 32'd0, 5'd2, 0, 32'd0);
        chk("mis_pulse", 32'(misaligned), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_reg_write", 32'(wb_reg_write), 32'd0);
        chk("mis_no_req", 32'(req_hits - r0), 32'd0);

        // LW that never gets ready
        r0 = req_hits; s0 = stall_hits;
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'd0, 5'd4, 99, 32'd0);
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_req_cycles", 32'(req_hits - r0), 32'(TO));
        chk("to_stall", 32'(stall_hits - s0), 32'(TO));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            d = $urandom_range(0, TO + 1);
            if (kind < 4)
                run_instr(1'($urandom_range(0, 9) != 0), 1'b0, 1'b0, 1'($urandom), 1'b0,
                          f3, a, $urandom, 5'($urandom), 0, 32'd0);
            else if (kind < 7)
                run_instr(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), f3, a, $urandom,
                          5'($urandom), d, $urandom);
            else
                run_instr(1'b1, 1'b0, 1'b1, 1'($urandom), 1'b0, f3, a, $urandom,
                          5'($urandom), d, $urandom);
        end

        // Asynchronous reset during the second REQ cycle
        valid_in = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
        step();
        chk_en = 1'b0;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0400; reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd9;
        dmem_ready = 1'b0;
        step();
        step();
        chk("rst_mid_req_before", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        valid_in = 1'b0;
        q.delete();
        step();
        reset = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
        chk_en = 1'b1;
        r0 = req_hits;
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h1357_9BDF, 5'd1, 1, 32'd0);
        chk("post_rst_req_cycles", 32'(req_hits - r0), 32'd2);
        chk("post_rst_wdata", last_wdata, 32'h1357_9BDF);
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
        valid_in = 1'b0; exp_stall = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
